// File: rtl/mix_columns_iter_pkg.sv
// Shared constants, FSM state type and GF(2^8) helper for the MixColumns stage.
package mix_columns_iter_pkg;

    localparam int STATE_BITS = 128;
    localparam int W_BYTE = 8;
    localparam int N_COLS = 4;
    localparam logic [W_BYTE-1:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
    function automatic logic [W_BYTE-1:0] xtime(input logic [W_BYTE-1:0] b);
        return {b[W_BYTE-2:0], 1'b0} ^ (b[W_BYTE-1] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/gf_mix_column.sv
// Combinational single-column MixColumns / InvMixColumns; byte 0 of column is row 0.
module gf_mix_column
    import mix_columns_iter_pkg::*;
(
    input  logic        inv,
    input  logic [31:0] column,
    output logic [31:0] result
);

    logic [W_BYTE-1:0] a  [N_COLS];
    logic [W_BYTE-1:0] x2 [N_COLS];
    logic [W_BYTE-1:0] x4 [N_COLS];
    logic [W_BYTE-1:0] x8 [N_COLS];

    always_comb begin
        for (int i = 0; i < N_COLS; i++) begin
            a[i]  = column[W_BYTE*i +: W_BYTE];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
    end

    // 0e = 8+4+2, 0b = 8+2+1, 0d = 8+4+1, 09 = 8+1; forward uses 02, 03 = 2+1.
    always_comb begin
        result = '0;
        for (int i = 0; i < N_COLS; i++) begin
            if (inv) begin
                result[W_BYTE*i +: W_BYTE] =
                    (x8[i] ^ x4[i] ^ x2[i]) ^
                    (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4]) ^
                    (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4]) ^
                    (x8[(i+3)%4] ^ a[(i+3)%4]);
            end else begin
                result[W_BYTE*i +: W_BYTE] =
                    x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
            end
        end
    end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns stage: one state per handshake, COLS_PER_CYCLE columns per clock.
module mix_columns_iter
    import mix_columns_iter_pkg::*;
#(
    parameter int W_DATA         = STATE_BITS,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_DATA-1:0] in_data,
    input  logic              in_inv,
    input  logic              in_bypass,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_DATA-1:0] out_data
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
    if (W_DATA != STATE_BITS) begin : g_bad_width
        $error("mix_columns_iter: W_DATA must be 128");
    end

    localparam logic [1:0] LAST_COL = 2'(N_COLS - COLS_PER_CYCLE);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

    state_t            state;
    logic [1:0]        col;
    logic [W_DATA-1:0] state_buf;
    logic [W_DATA-1:0] mixed_buf;
    logic              inv_q;
    logic              accept;
    logic [31:0]       col_words [COLS_PER_CYCLE];
    logic [31:0]       col_mixed [COLS_PER_CYCLE];

    // A finishing block may hand off and take the next state on the same edge.
    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign out_data = state_buf;

    always_comb begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            for (int r = 0; r < 4; r++) begin
                col_words[g][W_BYTE*r +: W_BYTE] =
                    state_buf[32*r + W_BYTE*(int'(col) + g) +: W_BYTE];
            end
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        gf_mix_column u_col (
            .inv    (inv_q),
            .column (col_words[g]),
            .result (col_mixed[g])
        );
    end

    always_comb begin
        mixed_buf = state_buf;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            for (int r = 0; r < 4; r++) begin
                mixed_buf[32*r + W_BYTE*(int'(col) + g) +: W_BYTE] =
                    col_mixed[g][W_BYTE*r +: W_BYTE];
            end
        end
    end

    // Valid/ready: a transfer happens on any edge where valid and ready are both high;
    // valid and its data stay stable until that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            col       <= '0;
            out_valid <= 1'b0;
            state_buf <= '0;
            inv_q     <= 1'b0;
        end else if (accept) begin
            state_buf <= in_data;
            inv_q     <= in_inv;
            col       <= '0;
            if (in_bypass) begin
                state     <= ST_DONE;
                out_valid <= 1'b1;
            end else begin
                state     <= ST_BUSY;
                out_valid <= 1'b0;
            end
        end else begin
            case (state)
                ST_BUSY: begin
                    state_buf <= mixed_buf;
                    if (col == LAST_COL) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        col <= col + COL_STEP;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2, 4 columns per cycle) against a GF(2^8) model.
module tb_mix_columns_iter;

    localparam logic [127:0] VEC1_IN  = {32'h45454545, 32'h53535353, 32'h13131313, 32'hdbdbdbdb};
    localparam logic [127:0] VEC1_OUT = {32'hbcbcbcbc, 32'ha1a1a1a1, 32'h4d4d4d4d, 32'h8e8e8e8e};
    localparam logic [127:0] VEC2_IN  = {32'h5c5c5c5c, 32'h22222222, 32'h0a0a0a0a, 32'hf2f2f2f2};
    localparam logic [127:0] VEC2_OUT = {32'h9d9d9d9d, 32'h58585858, 32'hdcdcdcdc, 32'h9f9f9f9f};
    localparam logic [127:0] VEC3_IN  = {4{32'h01010101}};
    localparam logic [127:0] VEC4_IN  = {32'h4c4c4c4c, 32'h31313131, 32'h26262626, 32'h2d2d2d2d};
    localparam logic [127:0] VEC4_OUT = {32'hf8f8f8f8, 32'hbdbdbdbd, 32'h7e7e7e7e, 32'h4d4d4d4d};
    localparam int N_STREAM = 100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         in_inv    [3];
    logic         in_bypass [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];

    logic [127:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_inv    (in_inv[g]),
            .in_bypass (in_bypass[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );
    end

    // Shift-and-add multiply with full polynomial reduction.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
        logic [7:0] m [4];
        logic [7:0] acc;
        logic [127:0] r = '0;
        if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        for (int j = 0; j < 4; j++) begin
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k - row + 4) % 4], s[32*k + 8*j +: 8]);
                r[32*row + 8*j +: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic send(input int d, input logic [127:0] data, input logic inv, input logic byp);
        int waited = 0;
        bit done = 0;
        in_data[d] = data; in_inv[d] = inv; in_bypass[d] = byp; in_valid[d] = 1'b1;
        while (!done && waited < 200) begin
            @(negedge clk);
            if (in_ready[d]) done = 1;
            @(posedge clk); #1;
            waited++;
        end
        in_valid[d] = 1'b0; in_inv[d] = 1'b0; in_bypass[d] = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL accept_timeout dut=%0d: no accept within %0d cycles", d, waited);
        end
    endtask

    task automatic wait_latency(input int d, input int exp_edges, input string name);
        int edges = 0;
        while (!out_valid[d] && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        n_checks++;
        if (!out_valid[d] || edges !== exp_edges) begin
            n_fail++;
            $display("FAIL %s dut=%0d: out_valid after %0d edges (valid=%0b), required %0d",
                     name, d, edges, out_valid[d], exp_edges);
        end
    endtask

    task automatic take(input int d, input string name);
        logic [127:0] exp;
        @(negedge clk);
        out_ready[d] = 1'b1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (!out_valid[d] || out_data[d] !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d: got %h valid=%0b, required %h", name, d, out_data[d], out_valid[d], exp);
        end
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        for (int d = 0; d < 3; d++) begin
            n_checks += 3;
            if (out_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid dut=%0d: got %b, required 0", d, out_valid[d]); end
            if (in_ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut=%0d: got %b, required 1", d, in_ready[d]); end
            if (out_data[d] !== '0) begin n_fail++; $display("FAIL reset_data dut=%0d: got %h, required 0", d, out_data[d]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_forward(input int d);
        exp_q.push_back(VEC1_OUT);
        send(d, VEC1_IN, 1'b0, 1'b0);
        wait_latency(d, 4 >> d, "fwd_latency");
        take(d, "fwd_data");
    endtask

    task automatic test_inverse(input int d);
        exp_q.push_back(VEC1_IN);
        send(d, VEC1_OUT, 1'b1, 1'b0);
        wait_latency(d, 4 >> d, "inv_latency");
        take(d, "inv_roundtrip");
        exp_q.push_back(VEC2_OUT);
        send(d, VEC2_IN, 1'b0, 1'b0);
        wait_latency(d, 4 >> d, "col2_latency");
        take(d, "col_f20a225c");
        exp_q.push_back(VEC3_IN);
        send(d, VEC3_IN, 1'b0, 1'b0);
        wait_latency(d, 4 >> d, "col3_latency");
        take(d, "col_01010101");
        exp_q.push_back(VEC4_OUT);
        send(d, VEC4_IN, 1'b0, 1'b0);
        wait_latency(d, 4 >> d, "col4_latency");
        take(d, "col_2d26314c");
    endtask

    // The bypassed block is already valid right after its accept edge.
    task automatic test_bypass();
        logic [127:0] data = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(data);
        send(0, data, 1'b1, 1'b1);
        wait_latency(0, 0, "bypass_latency");
        take(0, "bypass_data");
    endtask

    task automatic test_backpressure();
        exp_q.push_back(VEC1_OUT);
        send(0, VEC1_IN, 1'b0, 1'b0);
        wait_latency(0, 4, "bp_latency");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid[0] = (i == 4);
            in_data[0] = {$urandom, $urandom, $urandom, $urandom};
            n_checks += 2;
            if (out_data[0] !== exp_q[0]) begin n_fail++; $display("FAIL bp_stable cycle=%0d: got %h, required %h", i, out_data[0], exp_q[0]); end
            if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle=%0d: got %b, required 0", i, in_ready[0]); end
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        n_checks += 2;
        if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b, required 1", out_valid[0]); end
        if (out_data[0] !== exp_q[0]) begin n_fail++; $display("FAIL bp_pulse_ignored: got %h, required %h", out_data[0], exp_q[0]); end
        in_data[0] = VEC1_OUT; in_inv[0] = 1'b1; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        #1;
        n_checks += 2;
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_drain_ready: got %b, required 1", in_ready[0]); end
        if (out_data[0] !== exp_q[0]) begin n_fail++; $display("FAIL bp_drain_data: got %h, required %h", out_data[0], exp_q[0]); end
        void'(exp_q.pop_front());
        exp_q.push_back(VEC1_IN);
        @(posedge clk); #1;
        in_valid[0] = 1'b0; in_inv[0] = 1'b0; out_ready[0] = 1'b0;
        n_checks++;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b, required 0", out_valid[0]); end
        wait_latency(0, 4, "bp_second_latency");
        take(0, "bp_second_data");
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(VEC1_OUT);
        send(0, VEC1_IN, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", out_valid[0]); end
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b, required 1", in_ready[0]); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_no_emit: got %b, required 0", out_valid[0]); end
        test_forward(0);
    endtask

    task automatic test_back_to_back(input int d);
        int got = 0;
        int cyc = 0;
        fork
            begin
                for (int i = 0; i < N_STREAM; i++) begin
                    logic [127:0] data = {$urandom, $urandom, $urandom, $urandom};
                    logic inv = 1'($urandom_range(0, 1));
                    logic byp = ($urandom_range(0, 4) == 0);
                    exp_q.push_back(byp ? data : mix_ref(data, inv));
                    send(d, data, inv, byp);
                end
            end
            begin
                while (got < N_STREAM && cyc < 20000) begin
                    @(posedge clk); #2;
                    out_ready[d] = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (out_valid[d] && out_ready[d]) begin
                        logic [127:0] exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                        n_checks++;
                        if (out_data[d] !== exp) begin
                            n_fail++;
                            $display("FAIL stream dut=%0d block=%0d: got %h, required %h", d, got, out_data[d], exp);
                        end
                        got++;
                    end
                    cyc++;
                end
                @(posedge clk); #2;
                out_ready[d] = 1'b0;
            end
        join
        n_checks += 2;
        if (got != N_STREAM) begin n_fail++; $display("FAIL stream_count dut=%0d: got %0d blocks, required %0d", d, got, N_STREAM); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_leftover dut=%0d: %0d expected entries left, required 0", d, exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; in_data[d] = '0; in_inv[d] = 1'b0;
            in_bypass[d] = 1'b0; out_ready[d] = 1'b0;
        end
        test_reset();
        test_forward(0);
        test_inverse(0);
        test_bypass();
        test_backpressure();
        test_reset_mid();
        for (int d = 1; d < 3; d++) begin
            test_forward(d);
            test_inverse(d);
        end
        for (int d = 0; d < 3; d++) test_back_to_back(d);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
